memset_stream_ctrl: RTL and testbench

Sequencing controller for the memset datapath inside a SNAX accelerator shell. On a start command it latches a fill byte and a byte count from the CSR inputs. It then emits exactly the required number of fill beats on a valid/ready output stream, with a byte strobe on the final partial beat. It reports busy, a one-cycle done pulse and a cycle-count performance CSR, so software can issue arbitrary-length memsets without feeding an input stream.

---
 rtl/memset_stream_if.sv | 13 +
 rtl/memset_stream_ctrl.sv | 96 +++++++++
 tb/tb_memset_stream_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/memset_stream_if.sv
// rtl/memset_stream_if.sv - output beat stream of the memset controller
interface memset_stream_if #(
  parameter int DataWidth = 512
) ();
  logic                   valid;
  logic                   ready;
  logic [DataWidth-1:0]   bits;
  logic [DataWidth/8-1:0] strb;
  logic                   last;

  modport master (output valid, bits, strb, last, input ready);
  modport slave  (input valid, bits, strb, last, output ready);
endinterface

// File: rtl/memset_stream_ctrl.sv
// rtl/memset_stream_ctrl.sv - memset sequencer: latches fill/len, emits fill beats, reports busy/done/cycles
module memset_stream_ctrl #(
  parameter int DataWidth = 512,
  parameter int LenWidth  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         ext_csr_i_0,
  input  logic [LenWidth-1:0] ext_csr_i_1,
  input  logic                ext_start_i,
  output logic                ext_busy_o,
  output logic                ext_done_o,
  output logic [31:0]         ext_csr_o_0,
  memset_stream_if.master     ext_data_o
);

  localparam int BytesPerBeat = DataWidth / 8;
  localparam int Log2Bpb      = $clog2(BytesPerBeat);
  localparam int BeatWidth    = LenWidth - Log2Bpb + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t               state_q, state_d;
  logic [7:0]           fill_q;
  logic [Log2Bpb-1:0]   tail_q;
  logic [BeatWidth-1:0] rem_q;
  logic [31:0]          cyc_q, cyc_inc, csr_q;
  logic [BeatWidth-1:0] beats;
  logic                 len_zero, accept, xfer, final_beat;
  logic                 unused_csr_bits;

  assign unused_csr_bits = ^ext_csr_i_0[31:8];

  assign beats    = BeatWidth'(ext_csr_i_1 >> Log2Bpb)
                  + BeatWidth'(|ext_csr_i_1[Log2Bpb-1:0]);
  assign len_zero = (ext_csr_i_1 == '0);
  assign accept   = (state_q == IDLE) && ext_start_i;
  // valid is purely a function of state, so a transfer is just ready while streaming
  assign xfer     = (state_q == STREAM) && ext_data_o.ready;
  assign final_beat = (rem_q == BeatWidth'(1));
  assign cyc_inc  = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ext_start_i) state_d = len_zero ? DONE : STREAM;
      STREAM:  if (xfer && final_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      tail_q <= '0;
      rem_q  <= '0;
      cyc_q  <= '0;
      csr_q  <= '0;
    end else if (accept) begin
      fill_q <= ext_csr_i_0[7:0];
      tail_q <= ext_csr_i_1[Log2Bpb-1:0];
      rem_q  <= beats;
      cyc_q  <= '0;
      if (len_zero) csr_q <= '0;
    end else if (state_q == STREAM) begin
      cyc_q <= cyc_inc;
      if (xfer) begin
        rem_q <= rem_q - BeatWidth'(1);
        if (final_beat) csr_q <= cyc_inc;
      end
    end
  end

  assign ext_busy_o       = (state_q != IDLE);
  assign ext_done_o       = (state_q == DONE);
  assign ext_csr_o_0      = csr_q;
  assign ext_data_o.valid = (state_q == STREAM);
  assign ext_data_o.bits  = {BytesPerBeat{fill_q}};
  assign ext_data_o.last  = (state_q == STREAM) && final_beat;

  // a zero tail means the final beat is full
  always_comb begin
    ext_data_o.strb = '0;
    for (int i = 0; i < BytesPerBeat; i++) begin
      ext_data_o.strb[i] = (state_q == STREAM)
                         && (!final_beat || (tail_q == '0) || (i < int'(tail_q)));
    end
  end

endmodule

// File: tb/tb_memset_stream_ctrl.sv
// tb/tb_memset_stream_ctrl.sv - randomized self-checking bench against a queue-free behavioural model
module tb_memset_stream_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] csr0, csr1;
  logic        start;
  logic        busy, done;
  logic [31:0] csr_out;

  memset_stream_if #(.DataWidth(512)) ds ();

  memset_stream_ctrl #(.DataWidth(512), .LenWidth(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ext_csr_i_0 (csr0),
    .ext_csr_i_1 (csr1),
    .ext_start_i (start),
    .ext_busy_o  (busy),
    .ext_done_o  (done),
    .ext_csr_o_0 (csr_out),
    .ext_data_o  (ds)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  logic [63:0] last_strb;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // model: beats left, pending done pulse, stream-cycle count, last reported count
  longint      m_left;
  bit          m_done;
  logic [7:0]  m_fill;
  int          m_tail;
  logic [31:0] m_cyc, m_csr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 0; m_cyc = 0; m_csr = 0; m_fill = 0; m_tail = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_cyc = (m_cyc == 32'hFFFF_FFFF) ? m_cyc : m_cyc + 1;
      if (ds.ready) begin
        m_left--;
        if (m_left == 0) begin m_done = 1; m_csr = m_cyc; end
      end
    end else if (start) begin
      m_fill = csr0[7:0];
      m_left = (longint'(csr1) + 63) / 64;
      m_tail = int'(csr1 % 64);
      m_cyc  = 0;
      if (m_left == 0) begin m_done = 1; m_csr = 0; end
    end
  end

  always @(negedge clk) begin
    logic [63:0] exp_strb;
    chk("busy", busy, (m_left > 0) || m_done);
    chk("done", done, m_done);
    chk("valid", ds.valid, m_left > 0);
    chk("csr_o", csr_out, m_csr);
    if (m_left > 0) begin
      exp_strb = (m_left == 1 && m_tail != 0) ? (64'd1 << m_tail) - 64'd1 : '1;
      chk("bits", ds.bits, {64{m_fill}});
      chk("strb", ds.strb, exp_strb);
      chk("last", ds.last, m_left == 1);
    end
    if (ds.valid && ds.ready) begin
      xfer_cnt++;
      if (ds.last) last_strb = ds.strb;
    end
    if (done) done_cnt++;
  end

  logic ready_q[$];
  bit   rnd_ready = 0;
  always @(posedge clk) begin
    #2;
    if (ready_q.size() > 0) ds.ready = ready_q.pop_front();
    else if (rnd_ready)     ds.ready = 1'($urandom_range(0, 1));
    else                    ds.ready = 1'b1;
  end

  task automatic issue(input logic [7:0] f, input logic [31:0] l);
    @(posedge clk); #1;
    csr0 = {$urandom} & 32'hFFFF_FF00 | {24'd0, f};
    csr1 = l;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    csr0 = $urandom;
    csr1 = $urandom;
  endtask

  task automatic wait_done(output int lat);
    bit got = 0;
    lat = 0;
    for (int k = 0; k < 5000 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
  endtask

  task automatic reset_check(input string tag);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, ds.valid, 0);
    chk({tag, "_last"}, ds.last, 0);
    chk({tag, "_strb"}, ds.strb, 0);
    chk({tag, "_bits"}, ds.bits, 0);
    chk({tag, "_csr"}, csr_out, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int lat, base_x, base_d;
    rst_n = 0; start = 0; csr0 = 0; csr1 = 0; ds.ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", ds.valid, 0);
    chk("rst_bits", ds.bits, 0);
    chk("rst_csr", csr_out, 0);
    rst_n = 1;

    issue(8'hA5, 128); wait_done(lat);
    chk("t1_latency", lat, 3);
    chk("t1_csr", csr_out, 2);

    issue(8'h3E, 100); wait_done(lat);
    chk("t2_latency", lat, 3);
    chk("t2_tail_strb", last_strb, 64'h0000_000F_FFFF_FFFF);

    ready_q.push_back(1); ready_q.push_back(0); ready_q.push_back(0); ready_q.push_back(1);
    issue(8'h11, 64); wait_done(lat);
    chk("t3_latency", lat, 4);
    #1 chk("t3_csr", csr_out, 3);

    issue(8'h22, 0); wait_done(lat);
    chk("t4_latency", lat, 1);
    chk("t4_csr", csr_out, 0);

    // start during DONE must be dropped
    issue(8'h44, 64); wait_done(lat);
    start = 1; csr1 = 64;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    chk("done_start_ignored", busy, 0);

    rnd_ready = 1;
    base_x = xfer_cnt; base_d = done_cnt;
    issue(8'h3C, 640);
    repeat (3) begin
      @(posedge clk); #1;
      start = 1; csr0 = 32'hFF; csr1 = 64;
    end
    @(posedge clk); #1 start = 0;
    wait_done(lat);
    @(negedge clk);
    chk("mid_start_beats", xfer_cnt - base_x, 10);
    chk("mid_start_dones", done_cnt - base_d, 1);

    rnd_ready = 0;
    base_x = xfer_cnt; base_d = done_cnt;
    issue(8'h5A, 640);
    for (int k = 0; k < 100 && xfer_cnt < base_x + 4; k++) @(negedge clk);
    reset_check("midrst");
    chk("midrst_no_done", done_cnt - base_d, 0);
    issue(8'h66, 64); wait_done(lat);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_csr", csr_out, 1);

    rnd_ready = 1;
    issue(8'h77, 32'hFFFF_FFFF);
    repeat (30) @(negedge clk);
    reset_check("maxlen");

    for (int n = 0; n < 30; n++) begin
      logic [31:0] l;
      rnd_ready = $urandom_range(0, 1);
      l = (n % 4 == 0) ? 32'($urandom_range(0, 10)) * 64 : 32'($urandom_range(0, 700));
      issue(8'($urandom), l);
      wait_done(lat);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
